// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and lane helpers for the N-port RAM arbiter
package ram_arb_pkg;

   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } arb_mode_e;

   // Field widths cover up to 8 ports and 256 lanes per RAM word.
   localparam int IDX_W  = 3;
   localparam int LANE_W = 8;

   function automatic int lane_lo(input int in_width);
      return $clog2(in_width / 8);
   endfunction

   function automatic int lane_hi(input int out_width);
      return $clog2(out_width / 8) - 1;
   endfunction

   typedef struct packed {
      logic              valid;
      logic [IDX_W-1:0]  idx;
      logic [LANE_W-1:0] lane;
   } rsp_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - fixed-priority or round-robin one-hot arbiter
// The round-robin pointer moves to the port after the winner and holds when idle.
module rr_arbiter
   import ram_arb_pkg::*;
#(
   parameter int        NUM_PORTS = 3,
   parameter arb_mode_e ARB_MODE  = ARB_RR,
   localparam int       PW        = $clog2(NUM_PORTS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_PORTS-1:0] req_i,
   output logic [NUM_PORTS-1:0] gnt_o,
   output logic [PW-1:0]        gnt_idx_o,
   output logic                 gnt_valid_o
);

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;
   logic [PW:0]   cand;
   logic          found;

   // Search ports in priority order; the first requester found wins.
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      cand      = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (ARB_MODE == ARB_RR) begin
            cand = {1'b0, ptr_q} + (PW+1)'(i);
            if (cand >= (PW+1)'(NUM_PORTS)) begin
               cand = cand - (PW+1)'(NUM_PORTS);
            end
         end else begin
            cand = (PW+1)'(i);
         end
         for (int j = 0; j < NUM_PORTS; j++) begin
            if (!found && req_i[j] && cand == (PW+1)'(j)) begin
               found     = 1'b1;
               gnt_o[j]  = 1'b1;
               gnt_idx_o = PW'(j);
            end
         end
      end
   end

   assign gnt_valid_o = found;

   always_comb begin
      ptr_d = ptr_q;
      if (found) begin
         ptr_d = (gnt_idx_o == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx_o + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/ram_arbiter_n.sv
// rtl/ram_arbiter_n.sv - N-port arbiter onto one wide single-port RAM
// Narrow ports are lane-shifted onto the RAM word; responses return after RAM_LATENCY cycles.
module ram_arbiter_n
   import ram_arb_pkg::*;
#(
   parameter int        NUM_PORTS   = 3,
   parameter int        ADDR_WIDTH  = 32,
   parameter int        OUT_WIDTH   = 128,
   parameter int        IN_WIDTH    = 32,
   parameter arb_mode_e ARB_MODE    = ARB_RR,
   parameter int        RAM_LATENCY = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_PORTS-1:0]            port_req_i,
   output logic [NUM_PORTS-1:0]            port_gnt_o,
   output logic [NUM_PORTS-1:0]            port_rvalid_o,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr_i,
   input  logic [NUM_PORTS-1:0]            port_we_i,
   input  logic [NUM_PORTS*IN_WIDTH/8-1:0] port_be_i,
   input  logic [NUM_PORTS*IN_WIDTH-1:0]   port_wdata_i,
   output logic [NUM_PORTS*IN_WIDTH-1:0]   port_rdata_o,
   output logic                            ram_en_o,
   output logic [ADDR_WIDTH-1:0]           ram_addr_o,
   output logic                            ram_we_o,
   output logic [OUT_WIDTH/8-1:0]          ram_be_o,
   output logic [OUT_WIDTH-1:0]            ram_wdata_o,
   input  logic [OUT_WIDTH-1:0]            ram_rdata_i
);

   localparam int BE_IN = IN_WIDTH / 8;
   localparam int RATIO = OUT_WIDTH / IN_WIDTH;
   localparam int LLO   = lane_lo(IN_WIDTH);
   localparam int LHI   = lane_hi(OUT_WIDTH);
   localparam int PW    = $clog2(NUM_PORTS);
   localparam int LW    = (RATIO > 1) ? (LHI - LLO + 1) : 1;

   logic [PW-1:0]         gnt_idx;
   logic                  gnt_valid;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic                  sel_we;
   logic [BE_IN-1:0]      sel_be;
   logic [IN_WIDTH-1:0]   sel_wdata;
   logic [LW-1:0]         req_lane;
   rsp_entry_t            entry_d;
   rsp_entry_t            pipe_q [RAM_LATENCY];
   rsp_entry_t            rsp;
   logic [IN_WIDTH-1:0]   rsp_slice;

   rr_arbiter #(
      .NUM_PORTS (NUM_PORTS),
      .ARB_MODE  (ARB_MODE)
   ) u_arb (
      .clk         (clk),
      .rst         (rst),
      .req_i       (port_req_i),
      .gnt_o       (port_gnt_o),
      .gnt_idx_o   (gnt_idx),
      .gnt_valid_o (gnt_valid)
   );

   // gnt_idx is zero when idle, so an idle RAM sees port 0's fields.
   always_comb begin
      sel_addr  = port_addr_i[ADDR_WIDTH-1:0];
      sel_we    = port_we_i[0];
      sel_be    = port_be_i[BE_IN-1:0];
      sel_wdata = port_wdata_i[IN_WIDTH-1:0];
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (gnt_idx == PW'(p)) begin
            sel_addr  = port_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
            sel_we    = port_we_i[p];
            sel_be    = port_be_i[p*BE_IN +: BE_IN];
            sel_wdata = port_wdata_i[p*IN_WIDTH +: IN_WIDTH];
         end
      end
   end

   generate
      if (RATIO > 1) begin : g_lane
         assign req_lane = sel_addr[LHI:LLO];
      end else begin : g_no_lane
         assign req_lane = 1'b0;
      end
   endgenerate

   always_comb begin
      ram_be_o = '0;
      for (int l = 0; l < RATIO; l++) begin
         if (gnt_valid && req_lane == LW'(l)) begin
            ram_be_o[l*BE_IN +: BE_IN] = sel_be;
         end
      end
   end

   assign ram_en_o    = |port_req_i;
   assign ram_addr_o  = sel_addr;
   assign ram_we_o    = sel_we;
   assign ram_wdata_o = {RATIO{sel_wdata}};

   assign entry_d.valid = gnt_valid;
   assign entry_d.idx   = IDX_W'(gnt_idx);
   assign entry_d.lane  = LANE_W'(req_lane);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < RAM_LATENCY; s++) begin
            pipe_q[s] <= '0;
         end
      end else begin
         pipe_q[0] <= entry_d;
         for (int s = 1; s < RAM_LATENCY; s++) begin
            pipe_q[s] <= pipe_q[s-1];
         end
      end
   end

   assign rsp = pipe_q[RAM_LATENCY-1];

   always_comb begin
      port_rvalid_o = '0;
      rsp_slice     = ram_rdata_i[IN_WIDTH-1:0];
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (rsp.valid && rsp.idx == IDX_W'(p)) begin
            port_rvalid_o[p] = 1'b1;
         end
      end
      for (int l = 0; l < RATIO; l++) begin
         if (rsp.lane == LANE_W'(l)) begin
            rsp_slice = ram_rdata_i[l*IN_WIDTH +: IN_WIDTH];
         end
      end
   end

   assign port_rdata_o = {NUM_PORTS{rsp_slice}};

endmodule

// File: tb/tb_ram_arbiter_n.sv
// tb/tb_ram_arbiter_n.sv - directed bench over fixed, round-robin and deeper-latency arbiters
module tb_ram_arbiter_n;
   import ram_arb_pkg::*;

   localparam int N  = 3;
   localparam int AW = 32;
   localparam int OW = 128;
   localparam int IW = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [N-1:0]      req;
   logic [N-1:0]      we;
   logic [AW-1:0]     a [N];
   logic [3:0]        b [N];
   logic [IW-1:0]     w [N];
   logic [N*AW-1:0]   addr_f;
   logic [N*4-1:0]    be_f;
   logic [N*IW-1:0]   wd_f;
   logic [OW-1:0]     rdata;

   assign addr_f = {a[2], a[1], a[0]};
   assign be_f   = {b[2], b[1], b[0]};
   assign wd_f   = {w[2], w[1], w[0]};

   // instance 0: fixed/lat1, 1: rr/lat1, 2: rr/lat3, 3: rr/lat2
   logic [N-1:0]    gnt   [4];
   logic [N-1:0]    rv    [4];
   logic [N*IW-1:0] prd   [4];
   logic            en    [4];
   logic            rwe   [4];
   logic [AW-1:0]   raddr [4];
   logic [OW/8-1:0] rbe   [4];
   logic [OW-1:0]   rwd   [4];

   for (genvar g = 0; g < 4; g++) begin : g_dut
      ram_arbiter_n #(
         .NUM_PORTS   (N),
         .ADDR_WIDTH  (AW),
         .OUT_WIDTH   (OW),
         .IN_WIDTH    (IW),
         .ARB_MODE    ((g == 0) ? ARB_FIXED : ARB_RR),
         .RAM_LATENCY ((g == 2) ? 3 : (g == 3) ? 2 : 1)
      ) u_dut (
         .clk           (clk),
         .rst           (rst),
         .port_req_i    (req),
         .port_gnt_o    (gnt[g]),
         .port_rvalid_o (rv[g]),
         .port_addr_i   (addr_f),
         .port_we_i     (we),
         .port_be_i     (be_f),
         .port_wdata_i  (wd_f),
         .port_rdata_o  (prd[g]),
         .ram_en_o      (en[g]),
         .ram_addr_o    (raddr[g]),
         .ram_we_o      (rwe[g]),
         .ram_be_o      (rbe[g]),
         .ram_wdata_o   (rwd[g]),
         .ram_rdata_i   (rdata)
      );
   end

   int nvec = 0;
   int nbad = 0;
   logic [2:0] rr_seq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nbad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst   = 1'b1;
      req   = '0;
      we    = '0;
      rdata = '0;
      for (int i = 0; i < N; i++) begin
         a[i] = '0;
         b[i] = '0;
         w[i] = '0;
      end
      next_cycle();
      next_cycle();
      #1;
      for (int g = 0; g < 4; g++) begin
         check("rst_rvalid", rv[g], 3'b000);
         check("rst_gnt", gnt[g], 3'b000);
         check("rst_en", en[g], 1'b0);
         check("rst_be", rbe[g], 16'h0000);
      end
      rst = 1'b0;

      // all three request for 6 cycles: fixed always picks 0, rr rotates
      for (int c = 0; c < 7; c++) begin
         next_cycle();
         req = (c < 6) ? 3'b111 : 3'b000;
         #1;
         if (c < 6) begin
            check("fix_gnt", gnt[0], 3'b001);
            check("rr_gnt", gnt[1], rr_seq[c]);
         end
         if (c > 0) begin
            check("fix_rvalid", rv[0], 3'b001);
            check("rr_rvalid", rv[1], rr_seq[c-1]);
         end
      end

      // only port 2, then everyone: pointer wrapped to 0
      next_cycle();
      req = 3'b100;
      #1;
      check("rr_only2_gnt", gnt[1], 3'b100);
      next_cycle();
      req = 3'b111;
      #1;
      check("rr_wrap_gnt", gnt[1], 3'b001);
      check("rr_only2_rvalid", rv[1], 3'b100);

      // port 1 write to 0x18, lane 2
      next_cycle();
      req  = 3'b010;
      we   = 3'b010;
      a[0] = 32'h0000_0100;
      a[1] = 32'h0000_0018;
      b[1] = 4'b0011;
      w[1] = 32'hAABB_CCDD;
      #1;
      check("wr_gnt", gnt[1], 3'b010);
      check("wr_en", en[1], 1'b1);
      check("wr_addr", raddr[1], 32'h0000_0018);
      check("wr_we", rwe[1], 1'b1);
      check("wr_be", rbe[1], 16'h0300);
      check("wr_wdata", rwd[1], {4{32'hAABB_CCDD}});
      next_cycle();
      we = 3'b000;
      #1;
      check("wr_rvalid", rv[1], 3'b010);
      check("rd_we", rwe[1], 1'b0);
      check("rd_be", rbe[1], 16'h0300);
      next_cycle();
      req   = 3'b000;
      rdata = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      #1;
      check("rd_rvalid", rv[1], 3'b010);
      check("rd_rdata_p1", prd[1][63:32], 32'h3333_3333);
      check("idle_en", en[1], 1'b0);
      check("idle_be", rbe[1], 16'h0000);
      check("idle_addr", raddr[1], 32'h0000_0100);

      // latency 3: port0 lane1 at t0, port2 lane3 at t1
      next_cycle();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      next_cycle();
      req  = 3'b001;
      a[0] = 32'h0000_0004;
      a[2] = 32'h0000_000C;
      #1;
      check("l3_gnt0", gnt[2], 3'b001);
      next_cycle();
      req = 3'b100;
      #1;
      check("l3_gnt1", gnt[2], 3'b100);
      check("l3_rv_t1", rv[2], 3'b000);
      next_cycle();
      req = 3'b000;
      #1;
      check("l3_rv_t2", rv[2], 3'b000);
      next_cycle();
      #1;
      check("l3_rv_t3", rv[2], 3'b001);
      check("l3_rdata_p0", prd[2][31:0], 32'h2222_2222);
      next_cycle();
      #1;
      check("l3_rv_t4", rv[2], 3'b100);
      check("l3_rdata_p2", prd[2][95:64], 32'h4444_4444);
      next_cycle();
      #1;
      check("l3_rv_t5", rv[2], 3'b000);

      // latency 2: reset after an in-flight grant, request during reset
      next_cycle();
      req = 3'b001;
      #1;
      check("l2_gnt_d0", gnt[3], 3'b001);
      next_cycle();
      rst = 1'b1;
      req = 3'b010;
      #1;
      check("l2_rv_d1", rv[3], 3'b000);
      next_cycle();
      rst = 1'b0;
      req = 3'b000;
      #1;
      check("l2_rv_d2", rv[3], 3'b000);
      next_cycle();
      req = 3'b111;
      #1;
      check("l2_rv_d3", rv[3], 3'b000);
      check("l2_ptr_zero", gnt[3], 3'b001);
      next_cycle();
      req = 3'b000;
      #1;
      check("l2_rv_d4", rv[3], 3'b000);
      next_cycle();
      #1;
      check("l2_rv_d5", rv[3], 3'b001);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
